operand_latch_p3: RTL and testbench

OPERAND_LATCH_P3 -- requirements
Module: operand_latch_p3

---
 rtl/operand_latch_p3_if.sv | 53 +++++
 rtl/operand_latch_p3.sv | 81 ++++++++
 tb/tb_operand_latch_p3.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/operand_latch_p3_if.sv
// Stage-2 to stage-3 operand/control bundle for operand_latch_p3.
// stall_count exists only when OPERAND_LATCH_STALL_CNT_EN is defined.
interface operand_latch_p3_if #(
  parameter int DATA_W = 16
);
  logic                     valid_p2;
  logic [2:0]               read_addr_A_p2;
  logic [2:0]               read_addr_B_p2;
  logic signed [DATA_W-1:0] reg_data_A;
  logic signed [DATA_W-1:0] reg_data_B;
  logic signed [DATA_W-1:0] fowarding_data_A;
  logic signed [DATA_W-1:0] fowarding_data_B;
  logic                     to_foward_or_not_A;
  logic                     to_foward_or_not_B;
  logic [2:0]               write_addr_p2;
  logic                     write_p2;
  logic                     load_p2;
  logic [5:0]               ctrl_p2;
  logic                     flush;
  logic signed [DATA_W-1:0] operand_A_p3;
  logic signed [DATA_W-1:0] operand_B_p3;
  logic [2:0]               write_addr_p3;
  logic                     write_p3;
  logic                     load_p3;
  logic [5:0]               ctrl_p3;
  logic                     valid_p3;
  logic                     stall;
`ifdef OPERAND_LATCH_STALL_CNT_EN
  logic [7:0]               stall_count;
`endif

  modport master (
    output valid_p2, read_addr_A_p2, read_addr_B_p2, reg_data_A, reg_data_B,
           fowarding_data_A, fowarding_data_B, to_foward_or_not_A, to_foward_or_not_B,
           write_addr_p2, write_p2, load_p2, ctrl_p2, flush,
`ifdef OPERAND_LATCH_STALL_CNT_EN
    input  stall_count,
`endif
    input  operand_A_p3, operand_B_p3, write_addr_p3, write_p3, load_p3, ctrl_p3,
           valid_p3, stall
  );

  modport slave (
    input  valid_p2, read_addr_A_p2, read_addr_B_p2, reg_data_A, reg_data_B,
           fowarding_data_A, fowarding_data_B, to_foward_or_not_A, to_foward_or_not_B,
           write_addr_p2, write_p2, load_p2, ctrl_p2, flush,
`ifdef OPERAND_LATCH_STALL_CNT_EN
    output stall_count,
`endif
    output operand_A_p3, operand_B_p3, write_addr_p3, write_p3, load_p3, ctrl_p3,
           valid_p3, stall
  );
endinterface

// File: rtl/operand_latch_p3.sv
// Stage-3 operand latch with load-use hazard bubble insertion and flush squash.
// Optional saturating stall counter enabled by OPERAND_LATCH_STALL_CNT_EN.
module operand_latch_p3 #(
  parameter int DATA_W = 16
) (
  input logic               clock,
  input logic               reset,
  operand_latch_p3_if.slave bus
);

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t state;
  logic   addr_match;
  logic   stall_c;

  function automatic logic signed [DATA_W-1:0] pick_operand(
    input logic                     fwd,
    input logic signed [DATA_W-1:0] fwd_data,
    input logic signed [DATA_W-1:0] rf_data
  );
    return fwd ? fwd_data : rf_data;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Reset gates the hazard so upstream never sees a stall while stage 3 is being cleared.
  assign addr_match = (bus.read_addr_A_p2 == bus.write_addr_p3) |
                      (bus.read_addr_B_p2 == bus.write_addr_p3);
  assign stall_c    = bus.valid_p3 & bus.load_p3 & bus.write_p3 & bus.valid_p2 &
                      addr_match & ~bus.flush & (state == RUN) & ~reset;
  assign bus.stall  = stall_c;

  // Stage 2 -> stage 3 boundary
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= RUN;
      bus.valid_p3      <= 1'b0;
      bus.write_p3      <= 1'b0;
      bus.load_p3       <= 1'b0;
      bus.ctrl_p3       <= '0;
      bus.write_addr_p3 <= '0;
      bus.operand_A_p3  <= '0;
      bus.operand_B_p3  <= '0;
    end else begin
      state <= stall_c ? BUBBLE : RUN;
      if (bus.flush || stall_c) begin
        bus.valid_p3      <= 1'b0;
        bus.write_p3      <= 1'b0;
        bus.load_p3       <= 1'b0;
        bus.ctrl_p3       <= '0;
        bus.write_addr_p3 <= '0;
        bus.operand_A_p3  <= '0;
        bus.operand_B_p3  <= '0;
      end else begin
        bus.valid_p3      <= bus.valid_p2;
        bus.write_p3      <= bus.write_p2 & bus.valid_p2;
        bus.load_p3       <= bus.load_p2 & bus.valid_p2;
        bus.ctrl_p3       <= bus.ctrl_p2;
        bus.write_addr_p3 <= bus.write_addr_p2;
        bus.operand_A_p3  <= pick_operand(bus.to_foward_or_not_A, bus.fowarding_data_A,
                                          bus.reg_data_A);
        bus.operand_B_p3  <= pick_operand(bus.to_foward_or_not_B, bus.fowarding_data_B,
                                          bus.reg_data_B);
      end
    end
  end

`ifdef OPERAND_LATCH_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.stall_count <= 8'd0;
    end else if (stall_c) begin
      bus.stall_count <= sat_inc8(bus.stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_operand_latch_p3.sv
// Scoreboard bench for operand_latch_p3: stimulus queues expectations, a negedge monitor checks them.
module tb_operand_latch_p3;

  typedef struct {
    logic        rst, flush, vld, wr, ld, sa, sb;
    logic [2:0]  ra, rb, wa;
    logic [5:0]  ctrl;
    logic [15:0] da, db, fa, fb;
  } stim_t;

  typedef struct {
    logic        stall, vld, wr, ld;
    logic [2:0]  wa;
    logic [5:0]  ctrl;
    logic [15:0] a, b;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  operand_latch_p3_if #(.DATA_W(16)) bus ();
  operand_latch_p3 #(.DATA_W(16)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s act=%0h req=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t ins(logic v, logic [2:0] ra, logic [2:0] rb, logic [2:0] wa,
                                logic w, logic l, logic [5:0] c, logic [15:0] da, logic [15:0] db);
    stim_t s;
    s.rst = 1'b0; s.flush = 1'b0; s.vld = v; s.wr = w; s.ld = l; s.sa = 1'b0; s.sb = 1'b0;
    s.ra = ra; s.rb = rb; s.wa = wa; s.ctrl = c; s.da = da; s.db = db;
    s.fa = 16'h5555; s.fb = 16'h6666;
    return s;
  endfunction

  function automatic exp_t ex(logic st, logic v, logic [2:0] wa, logic w, logic l,
                              logic [5:0] c, logic [15:0] a, logic [15:0] b);
    exp_t e;
    e.stall = st; e.vld = v; e.wa = wa; e.wr = w; e.ld = l; e.ctrl = c; e.a = a; e.b = b;
    return e;
  endfunction

  function automatic exp_t bub(logic st);
    return ex(st, 1'b0, 3'd0, 1'b0, 1'b0, 6'd0, 16'd0, 16'd0);
  endfunction

  // One clock of stimulus: drive after the edge, queue stall for this cycle and p3 for the next.
  task automatic cyc(input stim_t s, input exp_t e);
    @(posedge clock);
    #1;
    reset                  = s.rst;
    bus.flush              = s.flush;
    bus.valid_p2           = s.vld;
    bus.read_addr_A_p2     = s.ra;
    bus.read_addr_B_p2     = s.rb;
    bus.write_addr_p2      = s.wa;
    bus.write_p2           = s.wr;
    bus.load_p2            = s.ld;
    bus.ctrl_p2            = s.ctrl;
    bus.reg_data_A         = s.da;
    bus.reg_data_B         = s.db;
    bus.fowarding_data_A   = s.fa;
    bus.fowarding_data_B   = s.fb;
    bus.to_foward_or_not_A = s.sa;
    bus.to_foward_or_not_B = s.sb;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t cur, prev;
    bit   have = 1'b0;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        cur = q.pop_front();
        if (have) begin
          chk("valid_p3",      32'(bus.valid_p3),                prev.vld);
          chk("write_p3",      32'(bus.write_p3),                prev.wr);
          chk("load_p3",       32'(bus.load_p3),                 prev.ld);
          chk("write_addr_p3", 32'(bus.write_addr_p3),           32'(prev.wa));
          chk("ctrl_p3",       32'(bus.ctrl_p3),                 32'(prev.ctrl));
          chk("operand_A_p3",  32'($unsigned(bus.operand_A_p3)), 32'(prev.a));
          chk("operand_B_p3",  32'($unsigned(bus.operand_B_p3)), 32'(prev.b));
        end
        chk("stall", 32'(bus.stall), 32'(cur.stall));
        prev = cur;
        have = 1'b1;
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    stim_t nop;
    nop = ins(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 6'd0, 16'd0, 16'd0);
    s = nop; s.rst = 1'b1;
    cyc(s, bub(1'b0));
    cyc(s, bub(1'b0));

    cyc(ins(1, 3'd1, 3'd2, 3'd4, 1, 0, 6'h15, 16'h1234, 16'h00FF),
        ex(0, 1, 3'd4, 1, 0, 6'h15, 16'h1234, 16'h00FF));
    s = ins(1, 3'd5, 3'd6, 3'd7, 1, 0, 6'h2A, 16'hAAAA, 16'h0000);
    s.sb = 1'b1; s.fb = 16'hBEEF; s.fa = 16'h1111;
    cyc(s, ex(0, 1, 3'd7, 1, 0, 6'h2A, 16'hAAAA, 16'hBEEF));
    s = ins(0, 3'd1, 3'd1, 3'd3, 1, 1, 6'h3F, 16'h0000, 16'h0000);
    s.sa = 1'b1; s.fa = 16'hCAFE;
    cyc(s, ex(0, 0, 3'd3, 0, 0, 6'h3F, 16'hCAFE, 16'h0000));

    // Load-use on r3 through port A: one bubble, then the held instruction lands.
    cyc(ins(1, 3'd0, 3'd0, 3'd3, 1, 1, 6'h01, 16'h0011, 16'h0022),
        ex(0, 1, 3'd3, 1, 1, 6'h01, 16'h0011, 16'h0022));
    s = ins(1, 3'd3, 3'd2, 3'd5, 1, 0, 6'h10, 16'h0101, 16'h0202);
    cyc(s, bub(1'b1));
    cyc(s, ex(0, 1, 3'd5, 1, 0, 6'h10, 16'h0101, 16'h0202));

    // Back-to-back loads to r2, each use pays exactly one bubble.
    cyc(ins(1, 3'd0, 3'd0, 3'd2, 1, 1, 6'h02, 16'h0007, 16'h0008),
        ex(0, 1, 3'd2, 1, 1, 6'h02, 16'h0007, 16'h0008));
    s = ins(1, 3'd6, 3'd2, 3'd2, 1, 1, 6'h03, 16'h0009, 16'h000A);
    cyc(s, bub(1'b1));
    cyc(s, ex(0, 1, 3'd2, 1, 1, 6'h03, 16'h0009, 16'h000A));
    s = ins(1, 3'd4, 3'd2, 3'd1, 1, 0, 6'h04, 16'h000B, 16'h000C);
    cyc(s, bub(1'b1));
    cyc(s, ex(0, 1, 3'd1, 1, 0, 6'h04, 16'h000B, 16'h000C));

    cyc(ins(1, 3'd0, 3'd0, 3'd0, 1, 1, 6'h05, 16'h0001, 16'h0002),
        ex(0, 1, 3'd0, 1, 1, 6'h05, 16'h0001, 16'h0002));
    s = ins(1, 3'd0, 3'd7, 3'd3, 1, 0, 6'h06, 16'h0003, 16'h0004);
    cyc(s, bub(1'b1));
    cyc(s, ex(0, 1, 3'd3, 1, 0, 6'h06, 16'h0003, 16'h0004));

    // Flush beats the hazard.
    cyc(ins(1, 3'd1, 3'd1, 3'd3, 1, 1, 6'h07, 16'h0005, 16'h0006),
        ex(0, 1, 3'd3, 1, 1, 6'h07, 16'h0005, 16'h0006));
    s = ins(1, 3'd3, 3'd3, 3'd4, 1, 0, 6'h08, 16'h0007, 16'h0008);
    s.flush = 1'b1;
    cyc(s, bub(1'b0));
    s.flush = 1'b0;
    cyc(s, ex(0, 1, 3'd4, 1, 0, 6'h08, 16'h0007, 16'h0008));

    cyc(ins(1, 3'd1, 3'd1, 3'd5, 1, 1, 6'h09, 16'h0001, 16'h0001),
        ex(0, 1, 3'd5, 1, 1, 6'h09, 16'h0001, 16'h0001));
    cyc(ins(0, 3'd5, 3'd5, 3'd6, 1, 0, 6'h0A, 16'h0002, 16'h0002),
        ex(0, 0, 3'd6, 0, 0, 6'h0A, 16'h0002, 16'h0002));

    // Reset while in BUBBLE, then a fresh hazard must still stall.
    cyc(ins(1, 3'd1, 3'd1, 3'd5, 1, 1, 6'h0B, 16'h0001, 16'h0001),
        ex(0, 1, 3'd5, 1, 1, 6'h0B, 16'h0001, 16'h0001));
    s = ins(1, 3'd5, 3'd0, 3'd6, 1, 0, 6'h0C, 16'h0003, 16'h0003);
    cyc(s, bub(1'b1));
    s.rst = 1'b1;
    cyc(s, bub(1'b0));
    cyc(ins(1, 3'd1, 3'd1, 3'd5, 1, 1, 6'h0D, 16'h0004, 16'h0004),
        ex(0, 1, 3'd5, 1, 1, 6'h0D, 16'h0004, 16'h0004));
    cyc(ins(1, 3'd2, 3'd5, 3'd6, 1, 0, 6'h0E, 16'h0005, 16'h0005), bub(1'b1));
    cyc(nop, bub(1'b0));

`ifdef OPERAND_LATCH_STALL_CNT_EN
    @(negedge clock);
    chk("stall_count_after_one", 32'(bus.stall_count), 32'd1);
    for (int i = 0; i < 300; i++) begin
      cyc(ins(1, 3'd0, 3'd0, 3'd3, 1, 1, 6'h01, 16'(i), 16'(i)),
          ex(0, 1, 3'd3, 1, 1, 6'h01, 16'(i), 16'(i)));
      s = ins(1, 3'd3, 3'd0, 3'd4, 1, 0, 6'h02, 16'h0005, 16'h0006);
      cyc(s, bub(1'b1));
      cyc(s, ex(0, 1, 3'd4, 1, 0, 6'h02, 16'h0005, 16'h0006));
    end
    cyc(nop, bub(1'b0));
    @(negedge clock);
    chk("stall_count_sat", 32'(bus.stall_count), 32'd255);
    s = nop; s.rst = 1'b1;
    cyc(s, bub(1'b0));
    cyc(nop, bub(1'b0));
    @(negedge clock);
    chk("stall_count_reset", 32'(bus.stall_count), 32'd0);
`endif

    cyc(nop, bub(1'b0));
    repeat (2) @(negedge clock);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
